// File: rtl/status_tx_pkg.sv
// Shared types and constants for the status UART transmitter.
// STATUS_TX_PARITY_EN adds the PARITY state to the byte FSM.
package status_tx_pkg;

  localparam int unsigned FRAME_LEN = 9;
  localparam int unsigned DATA_BITS = 8;

  localparam logic [7:0] ASCII_P  = 8'h50;
  localparam logic [7:0] ASCII_M  = 8'h4D;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef STATUS_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } txState_t;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] nibbleToAscii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/status_uart_tx_if.sv
// Request/status bundle between a status source and status_uart_tx.
interface status_uart_tx_if;

  logic       send;
  logic [7:0] player_hp;
  logic [7:0] mon_hp;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output send, player_hp, mon_hp,
    input  tx, busy, done
  );

  modport slave (
    input  send, player_hp, mon_hp,
    output tx, busy, done
  );

endinterface

// File: rtl/uart_tx_byte.sv
// Serialises one byte: start bit, 8 data bits LSB first, optional even
// parity (STATUS_TX_PARITY_EN), stop bit. A load seen in the last stop
// cycle chains straight into the next start bit with no idle gap.
module uart_tx_byte
  import status_tx_pkg::*;
#(
  parameter int unsigned BIT_DIV = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] dataByte,
  output logic       tx,
  output logic       byteDone_c
);

  localparam int unsigned CNT_W    = (BIT_DIV < 2) ? 1 : $clog2(BIT_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DIV - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  txState_t         state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [2:0]       bitIdx, bitIdxNext;
  logic [7:0]       dataQ, dataNext;
  logic             txNext;
  logic             bitEnd;

  assign bitEnd = (cnt == CNT_LAST);

  // State and datapath registers; tx is registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      bitIdx <= '0;
      dataQ  <= '0;
      tx     <= 1'b1;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      bitIdx <= bitIdxNext;
      dataQ  <= dataNext;
      tx     <= txNext;
    end
  end

  // Next-state, bit timing and line level.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    bitIdxNext = bitIdx;
    dataNext   = dataQ;
    byteDone_c = 1'b0;
    txNext     = 1'b1;

    case (state)
      IDLE: begin
        if (load) begin
          stateNext  = START;
          dataNext   = dataByte;
          cntNext    = '0;
          bitIdxNext = '0;
        end
      end
      START: begin
        if (bitEnd) begin
          stateNext = DATA;
          cntNext   = '0;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bitEnd) begin
          cntNext = '0;
          if (bitIdx == BIT_LAST) begin
`ifdef STATUS_TX_PARITY_EN
            stateNext = PARITY;
`else
            stateNext = STOP;
`endif
          end else begin
            bitIdxNext = bitIdx + 3'd1;
          end
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
`ifdef STATUS_TX_PARITY_EN
      PARITY: begin
        if (bitEnd) begin
          stateNext = STOP;
          cntNext   = '0;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (bitEnd) begin
          byteDone_c = 1'b1;
          cntNext    = '0;
          bitIdxNext = '0;
          if (load) begin
            stateNext = START;
            dataNext  = dataByte;
          end else begin
            stateNext = IDLE;
            dataNext  = '0;
          end
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      default: begin
        stateNext  = IDLE;
        cntNext    = '0;
        bitIdxNext = '0;
        dataNext   = '0;
      end
    endcase

    case (stateNext)
      START:   txNext = 1'b0;
      DATA:    txNext = dataNext[bitIdxNext];
`ifdef STATUS_TX_PARITY_EN
      PARITY:  txNext = ^dataNext;
`endif
      default: txNext = 1'b1;
    endcase
  end

endmodule

// File: rtl/status_uart_tx.sv
// Sends "P<hh> M<hh>\r\n" status frames over UART on each accepted send.
// Frame sequencing and formatting live here; bit timing is in uart_tx_byte.
// Build option: STATUS_TX_PARITY_EN adds an even parity bit to every byte.
module status_uart_tx
  import status_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic             clk,
  input  logic             reset_n,
  status_uart_tx_if.slave  bus
);

  localparam int unsigned BIT_DIV = CLK_HZ / BAUD;
  localparam int unsigned IDX_W   = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic             busyQ, busyNext;
  logic             doneQ, doneNext;
  logic [IDX_W-1:0] byteIdx, byteIdxNext;
  logic [7:0]       playerHpQ, playerHpNext;
  logic [7:0]       monHpQ, monHpNext;
  logic [IDX_W-1:0] fmtIdx_c;
  logic [7:0]       nextByte_c;
  logic             load_c;
  logic             byteDone_c;
  logic             txLine;

  // Frame byte at a given position; byte 0 is a constant so it can be
  // formatted before the HP values are captured.
  function automatic logic [7:0] frameByte(input logic [IDX_W-1:0] idx,
                                           input logic [7:0] pHp,
                                           input logic [7:0] mHp);
    case (idx)
      4'd0:    return ASCII_P;
      4'd1:    return nibbleToAscii(pHp[7:4]);
      4'd2:    return nibbleToAscii(pHp[3:0]);
      4'd3:    return ASCII_SP;
      4'd4:    return ASCII_M;
      4'd5:    return nibbleToAscii(mHp[7:4]);
      4'd6:    return nibbleToAscii(mHp[3:0]);
      4'd7:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

  assign fmtIdx_c   = busyQ ? IDX_W'(byteIdx + IDX_W'(1)) : '0;
  assign nextByte_c = frameByte(fmtIdx_c, playerHpQ, monHpQ);

  assign bus.tx   = txLine;
  assign bus.busy = busyQ;
  assign bus.done = doneQ;

  // Frame sequencing registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busyQ     <= 1'b0;
      doneQ     <= 1'b0;
      byteIdx   <= '0;
      playerHpQ <= '0;
      monHpQ    <= '0;
    end else begin
      busyQ     <= busyNext;
      doneQ     <= doneNext;
      byteIdx   <= byteIdxNext;
      playerHpQ <= playerHpNext;
      monHpQ    <= monHpNext;
    end
  end

  // Accept when idle, chain the next byte at each byte end, finish after LF.
  always_comb begin
    busyNext     = busyQ;
    doneNext     = 1'b0;
    byteIdxNext  = byteIdx;
    playerHpNext = playerHpQ;
    monHpNext    = monHpQ;
    load_c       = 1'b0;

    if (!busyQ) begin
      if (bus.send) begin
        load_c       = 1'b1;
        busyNext     = 1'b1;
        byteIdxNext  = '0;
        playerHpNext = bus.player_hp;
        monHpNext    = bus.mon_hp;
      end
    end else if (byteDone_c) begin
      if (byteIdx < LAST_IDX) begin
        load_c      = 1'b1;
        byteIdxNext = byteIdx + IDX_W'(1);
      end else begin
        busyNext    = 1'b0;
        doneNext    = 1'b1;
        byteIdxNext = '0;
      end
    end
  end

  // Byte serialiser.
  uart_tx_byte #(
    .BIT_DIV (BIT_DIV)
  ) u_byte (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load_c),
    .dataByte   (nextByte_c),
    .tx         (txLine),
    .byteDone_c (byteDone_c)
  );

endmodule

// File: doc/status_uart_tx.md
STATUS_UART_TX -- requirements
Module: status_uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate; BIT_DIV = CLK_HZ/BAUD (integer division), BIT_DIV >= 2.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low (one clock; reset is asynchronous and active-low).
REQ-005 SHALL have port send  input  1  request to transmit one status frame, sampled each cycle.
REQ-006 SHALL have port player_hp  input  8  player HP, unsigned.
REQ-007 SHALL have port mon_hp  input  8  monster HP, unsigned.
REQ-008 SHALL have port tx  output  1  UART serial line, idle high.
REQ-009 SHALL have port busy  output  1  high while a frame is in flight.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a frame completes.

Function
REQ-011 SHALL accept send only when busy=0; a send seen while busy=1 is ignored, not queued.
REQ-012 SHALL capture player_hp and mon_hp into internal registers in the accept cycle; later input changes do not affect the frame in flight.
REQ-013 SHALL raise busy in the cycle after acceptance and drive the first start bit (tx=0) in that same cycle.
REQ-014 SHALL send a 9-byte frame in order: 'P', hex(player_hp[7:4]), hex(player_hp[3:0]), ' ', 'M', hex(mon_hp[7:4]), hex(mon_hp[3:0]), CR (0x0D), LF (0x0A).
REQ-015 SHALL encode hex digits as uppercase ASCII: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
REQ-016 SHALL serialise each byte as 1 start bit (0), 8 data bits LSB first, optional parity bit (REQ-024), 1 stop bit (1); each bit is held exactly BIT_DIV cycles.
REQ-017 SHALL send bytes back-to-back: the next start bit begins in the cycle after the previous stop bit ends, with no extra idle cycles.
REQ-018 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START on accepted send; START->DATA after BIT_DIV cycles; DATA->PARITY (macro defined) or STOP after 8 bits; PARITY->STOP after BIT_DIV cycles; STOP->START if byte index < 8, else IDLE.
REQ-019 SHALL keep byte index 0..8 and bit index 0..7 counters; neither wraps during a frame; both clear on return to IDLE.
REQ-020 SHALL pulse done for exactly one cycle on the STOP->IDLE transition, drop busy in that same cycle, and accept a new send from the following cycle.
REQ-021 SHALL hold tx=1 in IDLE.

Reset
REQ-022 SHALL, while reset_n=0, immediately force tx=1, busy=0, done=0, FSM=IDLE, all counters and captured values to 0, including when a frame is in flight; no partial frame resumes.
REQ-023 SHALL accept send from the first rising edge after reset_n deasserts.

Configuration
REQ-024 SHALL, when STATUS_TX_PARITY_EN is defined, insert an even-parity bit (XOR of the 8 data bits) after bit 7 of every byte; frame = 11 bits/byte.
REQ-025 SHALL, when STATUS_TX_PARITY_EN is undefined, omit the PARITY state and its logic entirely; frame = 10 bits/byte.

Structure
REQ-026 SHALL place in shared package status_tx_pkg: FSM state enum, FRAME_LEN=9, ASCII constants ('P', 'M', ' ', CR, LF), and the nibble-to-ASCII function.
REQ-027 SHALL split byte serialisation into sub-module uart_tx_byte (load/byte in, tx, byte_done); status_uart_tx keeps frame sequencing and formatting.

Verification (CLK_HZ=100, BAUD=10 -> BIT_DIV=10)
REQ-028 SHALL cover player_hp=0x64, mon_hp=0x0A, send pulse -> decoded bytes 50 36 34 20 4D 30 41 0D 0A; busy high 900 cycles (990 with parity); one done pulse.
REQ-029 SHALL cover inputs changed to 0xFF/0xFF one cycle after acceptance -> frame still carries 64/0A.
REQ-030 SHALL cover send pulsed at cycles 50 and 400 of a frame -> ignored; exactly one frame and one done.
REQ-031 SHALL cover reset_n low at cycle 300 of a frame -> tx=1, busy=0 at once; send after release -> complete fresh frame.
REQ-032 SHALL cover send held high continuously -> frames back-to-back with done and re-acceptance one cycle apart; tx stays idle-high for exactly that one cycle.
REQ-033 SHALL cover STATUS_TX_PARITY_EN defined, byte 0x41 -> parity bit 0; byte 0x34 -> parity bit 1.
